// File: rtl/dram_resp_model_if.sv
// Handshake bundle between the DRAM port owner (master) and the responder (slave).
// All three channels transfer a beat in a cycle where rdy && ack.
interface dram_resp_model_if #(
  parameter int AW = 16,
  parameter int DW = 64
) ();
  logic            ra_rdy;
  logic            ra_ack;
  logic [AW-1:0]   ra_addr;
  logic            rd_rdy;
  logic            rd_ack;
  logic [DW-1:0]   rd_data;
  logic            w_rdy;
  logic            w_ack;
  logic [AW-1:0]   w_addr;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_mask;

  modport master (
    output ra_rdy, ra_addr, rd_ack, w_rdy, w_addr, w_data, w_mask,
    input  ra_ack, rd_rdy, rd_data, w_ack
  );

  modport slave (
    input  ra_rdy, ra_addr, rd_ack, w_rdy, w_addr, w_data, w_mask,
    output ra_ack, rd_rdy, rd_data, w_ack
  );
endinterface

// File: rtl/dram_resp_model.sv
// DRAM responder: word memory, fixed minimum read latency, in-order queue of
// outstanding reads and LFSR-driven backpressure on the request channels.
module dram_resp_model #(
  parameter int AW     = 16,
  parameter int DW     = 64,
  parameter int RD_LAT = 4,
  parameter int N_OUT  = 8
) (
  input  logic                i_clk,
  input  logic                i_rst,
  dram_resp_model_if.slave    bus,
  input  logic [1:0]          i_bp_mode,
  input  logic [15:0]         i_seed,
  output logic [31:0]         o_nrd,
  output logic [31:0]         o_nwr
);
  localparam int QW = $clog2(N_OUT);
  localparam int PW = QW + 1;
  localparam logic [8:0] LAT9 = 9'(RD_LAT);

  logic [DW-1:0] r_mem     [0:(1<<AW)-1];
  logic [DW-1:0] r_q_data  [0:N_OUT-1];
  logic [8:0]    r_q_stamp [0:N_OUT-1];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [8:0]    r_cyc;
  logic [15:0]   r_lfsr;
  logic          r_rd_rdy;
  logic [DW-1:0] r_rd_data;
  logic [31:0]   r_nrd;
  logic [31:0]   r_nwr;

  logic [PW-1:0] w_count;
  logic          w_full;
  logic          w_gate_ra;
  logic          w_gate_w;
  logic          w_ra_ack;
  logic          w_w_ack;
  logic          w_push;
  logic          w_wr;
  logic          w_pop;
  logic [DW-1:0] w_wmask_bits;
  logic [DW-1:0] w_snap;
  logic [PW-1:0] w_head_ptr;
  logic          w_head_avail;
  logic [8:0]    w_head_diff;
  logic          w_load;

  // Backpressure gates; the reserved mode behaves like always-accept
  always_comb begin
    w_gate_ra = 1'b1;
    w_gate_w  = 1'b1;
    case (i_bp_mode)
      2'd1: begin
        w_gate_ra = r_lfsr[0];
        w_gate_w  = r_lfsr[1];
      end
      2'd2: begin
        w_gate_ra = 1'b0;
        w_gate_w  = 1'b0;
      end
      default: begin
        w_gate_ra = 1'b1;
        w_gate_w  = 1'b1;
      end
    endcase
  end

  assign w_count  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[QW-1:0] == r_rd_ptr[QW-1:0]);
  // Acks are forced low while reset is held so nothing is accepted mid-reset
  assign w_ra_ack = i_rst && bus.ra_rdy && w_gate_ra && !w_full;
  assign w_w_ack  = i_rst && bus.w_rdy && w_gate_w;
  assign w_push   = bus.ra_rdy && w_ra_ack;
  assign w_wr     = bus.w_rdy && w_w_ack;
  assign w_pop    = r_rd_rdy && bus.rd_ack;

  // Byte-enable expansion and write-first read snapshot
  always_comb begin
    w_wmask_bits = '0;
    for (int b = 0; b < DW/8; b++) begin
      w_wmask_bits[b*8 +: 8] = {8{bus.w_mask[b]}};
    end
    w_snap = r_mem[bus.ra_addr];
    if (w_wr && (bus.w_addr == bus.ra_addr)) begin
      w_snap = (w_snap & ~w_wmask_bits) | (bus.w_data & w_wmask_bits);
    end else begin
      w_snap = r_mem[bus.ra_addr];
    end
  end

  // Pick the entry that becomes the presented head at the next edge
  always_comb begin
    w_head_ptr   = r_rd_ptr;
    w_head_avail = 1'b0;
    if (w_pop) begin
      w_head_ptr   = r_rd_ptr + PW'(1'b1);
      w_head_avail = (w_count > PW'(1'b1));
    end else begin
      w_head_ptr   = r_rd_ptr;
      w_head_avail = (w_count != PW'(1'b0));
    end
    w_head_diff = r_cyc - r_q_stamp[w_head_ptr[QW-1:0]];
    w_load      = (!r_rd_rdy || w_pop) && w_head_avail && !w_head_diff[8];
  end

  // Control state, output stage and counters
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cyc     <= 9'd0;
      r_lfsr    <= (i_seed == 16'h0000) ? 16'h0001 : i_seed;
      r_rd_rdy  <= 1'b0;
      r_rd_data <= '0;
      r_nrd     <= 32'd0;
      r_nwr     <= 32'd0;
    end else begin
      r_cyc  <= r_cyc + 9'd1;
      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1'b1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1'b1);
        r_nrd    <= r_nrd + 32'd1;
      end
      if (w_wr) begin
        r_nwr <= r_nwr + 32'd1;
      end
      if (w_load) begin
        r_rd_rdy  <= 1'b1;
        r_rd_data <= r_q_data[w_head_ptr[QW-1:0]];
      end else if (w_pop) begin
        r_rd_rdy <= 1'b0;
      end
    end
  end

  // Queue payload; emptiness is tracked by the pointers alone
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr[QW-1:0]]  <= w_snap;
      r_q_stamp[r_wr_ptr[QW-1:0]] <= r_cyc + LAT9;
    end
  end

  // Word memory with byte enables; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[bus.w_addr] <= (r_mem[bus.w_addr] & ~w_wmask_bits) |
                           (bus.w_data & w_wmask_bits);
    end
  end

  assign bus.ra_ack  = w_ra_ack;
  assign bus.w_ack   = w_w_ack;
  assign bus.rd_rdy  = r_rd_rdy;
  assign bus.rd_data = r_rd_data;
  assign o_nrd       = r_nrd;
  assign o_nwr       = r_nwr;
endmodule
